// File: rtl/mem_stage.sv
// mem_stage: data-memory access and M_WB pipeline register for the MIPS pipe.
// Ports: clk, rst (async high); EX_M_* inputs from EX; M_WB_* outputs to WB/fwd.
module mem_stage #(
   parameter int MEM_WORDS = 256,
   parameter int AW        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] EX_M_result,
   input  logic [31:0] EX_M_write_data,
   input  logic [4:0]  EX_M_rd,
   input  logic        EX_M_memread,
   input  logic        EX_M_memwrite,
   input  logic        EX_M_memtoreg,
   input  logic        EX_M_regwrite,
   output logic [31:0] M_WB_data,
   output logic [4:0]  M_WB_rd,
   output logic        M_WB_regwrite
);

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        memtoreg;
      logic        regwrite;
   } m_wb_t;

   logic [31:0]   r_mem [MEM_WORDS];
   m_wb_t         r_mwb;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_rdata;
   logic          w_unused_memread;

   // Byte offset and high address bits dropped: round-down and wrap.
   assign w_idx   = EX_M_result[AW+1:2];
   // Read is unconditional; memread only documents intent.
   assign w_rdata = r_mem[w_idx];
   assign w_unused_memread = EX_M_memread;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_WORDS; i++)
            r_mem[i] <= '0;
      end else if (EX_M_memwrite) begin
         r_mem[w_idx] <= EX_M_write_data;
      end
   end

   // Captures pre-write word, giving old-data read-during-write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mwb <= '0;
      end else begin
         r_mwb.rdata    <= w_rdata;
         r_mwb.alu      <= EX_M_result;
         r_mwb.rd       <= EX_M_rd;
         r_mwb.memtoreg <= EX_M_memtoreg;
         // $zero is never reported written, so EX never forwards into it.
         r_mwb.regwrite <= EX_M_regwrite & (EX_M_rd != 5'd0);
      end
   end

   assign M_WB_data     = r_mwb.memtoreg ? r_mwb.rdata : r_mwb.alu;
   assign M_WB_rd       = r_mwb.rd;
   assign M_WB_regwrite = r_mwb.regwrite;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// Directed scenarios plus randomized traffic against a word-array model.
module tb_mem_stage;

   localparam int MW = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] result, wdata;
   logic [4:0]  rd;
   logic        memread, memwrite, memtoreg, regwrite;
   logic [31:0] M_WB_data;
   logic [4:0]  M_WB_rd;
   logic        M_WB_regwrite;

   int checks = 0;
   int errors = 0;

   logic [31:0] model_mem [MW];
   logic [31:0] exp_data;
   logic [4:0]  exp_rd;
   logic        exp_rw;

   mem_stage #(.MEM_WORDS(MW), .AW(8)) dut (
      .clk(clk),
      .rst(rst),
      .EX_M_result(result),
      .EX_M_write_data(wdata),
      .EX_M_rd(rd),
      .EX_M_memread(memread),
      .EX_M_memwrite(memwrite),
      .EX_M_memtoreg(memtoreg),
      .EX_M_regwrite(regwrite),
      .M_WB_data(M_WB_data),
      .M_WB_rd(M_WB_rd),
      .M_WB_regwrite(M_WB_regwrite)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   function automatic int widx(input logic [31:0] a);
      return int'((a / 32'd4) % 32'(MW));
   endfunction

   task automatic model_clear();
      for (int i = 0; i < MW; i++) model_mem[i] = '0;
   endtask

   // Drive one EX_M instruction, predict M_WB, advance past the edge.
   task automatic cycle(input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] r, input logic mr,
                        input logic mw, input logic mt,
                        input logic rw);
      logic [31:0] old;
      @(negedge clk);
      result = a; wdata = d; rd = r;
      memread = mr; memwrite = mw; memtoreg = mt; regwrite = rw;
      old = model_mem[widx(a)];
      exp_data = mt ? old : a;
      exp_rd = r;
      exp_rw = rw && (r != 5'd0);
      if (mw) model_mem[widx(a)] = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      result = '0; wdata = '0; rd = '0;
      memread = 0; memwrite = 0; memtoreg = 0; regwrite = 0;
      model_clear();
      #12;
      checks++;
      if (M_WB_data !== 32'h0 || M_WB_rd !== 5'd0 || M_WB_regwrite !== 1'b0) begin
         errors++;
         $display("FAIL reset_init: got %h/%0d/%b want 0/0/0",
                  M_WB_data, M_WB_rd, M_WB_regwrite);
      end
      @(negedge clk); rst = 1'b0;
      cycle(32'h0, 32'h1234_5678, 5'd0, 0, 1, 0, 0);
      cycle(32'h0, 32'h0, 5'd7, 1, 0, 1, 1);
      checks++;
      if (M_WB_data !== 32'h1234_5678 || M_WB_regwrite !== 1'b1) begin
         errors++;
         $display("FAIL reset_preload: got %h/%b want 12345678/1",
                  M_WB_data, M_WB_regwrite);
      end
      // Store pending to word 0, reset asserted mid-cycle.
      @(negedge clk);
      result = 32'h0; wdata = 32'hBAD0_BAD0; rd = 5'd4;
      memread = 0; memwrite = 1; memtoreg = 0; regwrite = 1;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (M_WB_data !== 32'h0 || M_WB_rd !== 5'd0 || M_WB_regwrite !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: got %h/%0d/%b want 0/0/0",
                  M_WB_data, M_WB_rd, M_WB_regwrite);
      end
      model_clear();
      @(posedge clk); #1;
      checks++;
      if (M_WB_data !== 32'h0 || M_WB_regwrite !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: got %h/%b want 0/0", M_WB_data, M_WB_regwrite);
      end
      @(negedge clk);
      rst = 1'b0; memwrite = 0;
      cycle(32'h0, 32'h0, 5'd3, 1, 0, 1, 1);
      checks++;
      if (M_WB_data !== 32'h0 || M_WB_rd !== 5'd3 || M_WB_regwrite !== 1'b1) begin
         errors++;
         $display("FAIL reset_load0: got %h/%0d/%b want 0/3/1",
                  M_WB_data, M_WB_rd, M_WB_regwrite);
      end
   endtask

   task automatic test_store_load();
      cycle(32'h10, 32'hDEAD_BEEF, 5'd0, 0, 1, 0, 0);
      checks++;
      if (M_WB_regwrite !== 1'b0) begin
         errors++;
         $display("FAIL store_regwrite: got %b want 0", M_WB_regwrite);
      end
      cycle(32'h10, 32'h0, 5'd8, 1, 0, 1, 1);
      checks++;
      if (M_WB_data !== 32'hDEAD_BEEF || M_WB_rd !== 5'd8 || M_WB_regwrite !== 1'b1) begin
         errors++;
         $display("FAIL store_load: got %h/%0d/%b want deadbeef/8/1",
                  M_WB_data, M_WB_rd, M_WB_regwrite);
      end
      #3;
      checks++;
      if (M_WB_data !== 32'hDEAD_BEEF || M_WB_rd !== 5'd8) begin
         errors++;
         $display("FAIL store_load_stable: got %h/%0d want deadbeef/8",
                  M_WB_data, M_WB_rd);
      end
   endtask

   task automatic test_alu_passthrough();
      cycle(32'h0000_1234, 32'hFFFF_FFFF, 5'd5, 0, 0, 0, 1);
      checks++;
      if (M_WB_data !== 32'h1234 || M_WB_rd !== 5'd5 || M_WB_regwrite !== 1'b1) begin
         errors++;
         $display("FAIL alu_pass: got %h/%0d/%b want 1234/5/1",
                  M_WB_data, M_WB_rd, M_WB_regwrite);
      end
      cycle(32'h0000_1234, 32'h0, 5'd6, 1, 0, 1, 1);
      checks++;
      if (M_WB_data !== 32'h0) begin
         errors++;
         $display("FAIL alu_mem_untouched: got %h want 0", M_WB_data);
      end
   endtask

   task automatic test_boundaries();
      cycle(32'h3FF, 32'hA5A5_A5A5, 5'd0, 0, 1, 0, 0);
      cycle(32'h3FC, 32'h0, 5'd10, 1, 0, 1, 1);
      checks++;
      if (M_WB_data !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL bound_top: got %h want a5a5a5a5", M_WB_data);
      end
      cycle(32'h400, 32'h1111_1111, 5'd0, 0, 1, 0, 0);
      cycle(32'h0, 32'h0, 5'd11, 1, 0, 1, 1);
      checks++;
      if (M_WB_data !== 32'h1111_1111) begin
         errors++;
         $display("FAIL bound_wrap: got %h want 11111111", M_WB_data);
      end
      cycle(32'h3FC, 32'h0, 5'd12, 1, 0, 1, 1);
      checks++;
      if (M_WB_data !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL bound_top_kept: got %h want a5a5a5a5", M_WB_data);
      end
   endtask

   task automatic test_rw_same();
      cycle(32'h20, 32'h1, 5'd0, 0, 1, 0, 0);
      cycle(32'h20, 32'h2, 5'd9, 1, 1, 1, 1);
      checks++;
      if (M_WB_data !== 32'h1 || M_WB_regwrite !== 1'b1) begin
         errors++;
         $display("FAIL rw_same_old: got %h/%b want 1/1", M_WB_data, M_WB_regwrite);
      end
      cycle(32'h20, 32'h0, 5'd9, 1, 0, 1, 1);
      checks++;
      if (M_WB_data !== 32'h2) begin
         errors++;
         $display("FAIL rw_same_new: got %h want 2", M_WB_data);
      end
   endtask

   task automatic test_zero();
      cycle(32'h55, 32'h0, 5'd0, 0, 0, 0, 1);
      checks++;
      if (M_WB_regwrite !== 1'b0 || M_WB_rd !== 5'd0 || M_WB_data !== 32'h55) begin
         errors++;
         $display("FAIL zero_suppress: got %h/%0d/%b want 55/0/0",
                  M_WB_data, M_WB_rd, M_WB_regwrite);
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 400; n++) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_003F;
         cycle(a, $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         checks++;
         if (M_WB_data !== exp_data || M_WB_rd !== exp_rd ||
             M_WB_regwrite !== exp_rw) begin
            errors++;
            $display("FAIL random[%0d]: got %h/%0d/%b want %h/%0d/%b", n,
                     M_WB_data, M_WB_rd, M_WB_regwrite,
                     exp_data, exp_rd, exp_rw);
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_alu_passthrough();
      test_boundaries();
      test_rw_same();
      test_zero();
      idle();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
